// File: rtl/div_ctrl.sv
// EX-stage initiator for the multi-cycle divider: launches/annuls a divide, holds operands,
// stalls the pipeline while busy and captures {remainder,quotient} into HI/LO.
module div_ctrl #(
    parameter int DATA_W  = 24,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                div_req_i,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   reg1_i,
    input  logic [DATA_W-1:0]   reg2_i,
    input  logic                flush_i,
    input  logic [2*DATA_W-1:0] div_result_i,
    input  logic                div_ready_i,
    output logic                div_start_o,
    output logic                div_annul_o,
    output logic                div_signed_o,
    output logic [DATA_W-1:0]   div_op1_o,
    output logic [DATA_W-1:0]   div_op2_o,
    output logic                stallreq_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
    output logic                hilo_we_o,
    output logic                div_zero_o,
    output logic                timeout_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_q, start_d;
    logic               annul_q, annul_d;
    logic               signed_q, signed_d;
    logic [DATA_W-1:0]  op1_q, op1_d;
    logic [DATA_W-1:0]  op2_q, op2_d;
    logic [DATA_W-1:0]  hi_q, hi_d;
    logic [DATA_W-1:0]  lo_q, lo_d;
    logic               hilo_we_q, hilo_we_d;
    logic               zero_q, zero_d;
    logic               timeout_q, timeout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            annul_q   <= 1'b0;
            signed_q  <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            hilo_we_q <= 1'b0;
            zero_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            annul_q   <= annul_d;
            signed_q  <= signed_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            hilo_we_q <= hilo_we_d;
            zero_q    <= zero_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_d   = start_q;
        annul_d   = 1'b0;
        signed_d  = signed_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        hilo_we_d = 1'b0;
        zero_d    = zero_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (div_req_i && !flush_i) begin
                    op1_d    = reg1_i;
                    op2_d    = reg2_i;
                    signed_d = signed_i;
                    zero_d   = (reg2_i == '0);
                    start_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Flush outranks both the watchdog and a same-cycle result.
                if (flush_i) begin
                    start_d = 1'b0;
                    annul_d = 1'b1;
                    state_d = DRAIN;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1) && !div_ready_i) begin
                    start_d   = 1'b0;
                    annul_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = DRAIN;
                end else if (div_ready_i) begin
                    hi_d      = div_result_i[2*DATA_W-1:DATA_W];
                    lo_d      = div_result_i[DATA_W-1:0];
                    hilo_we_d = 1'b1;
                    start_d   = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                // Divider must drop ready before it can take another start.
                start_d = 1'b0;
                if (!div_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stallreq_o   = (div_req_i && !flush_i && (state_q == IDLE || state_q == DRAIN))
                          || (state_q == BUSY);
    assign div_start_o  = start_q;
    assign div_annul_o  = annul_q;
    assign div_signed_o = signed_q;
    assign div_op1_o    = op1_q;
    assign div_op2_o    = op2_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;
    assign hilo_we_o    = hilo_we_q;
    assign div_zero_o   = zero_q;
    assign timeout_o    = timeout_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: stub divider with programmable latency, a behavioural model of the
// controller checked every cycle, directed literal cases and a randomized run.
module tb_div_ctrl;
    localparam int DW = 24;
    localparam int TO = 16;
    localparam int M_IDLE = 0, M_BUSY = 1, M_DONE = 2, M_DRAIN = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          div_req = 1'b0;
    logic          sgn = 1'b0;
    logic [DW-1:0] reg1 = '0;
    logic [DW-1:0] reg2 = '0;
    logic          flush = 1'b0;
    logic [2*DW-1:0] div_result;
    logic          div_ready;
    logic          div_start_o, div_annul_o, div_signed_o, stallreq_o;
    logic [DW-1:0] div_op1_o, div_op2_o, hi_o, lo_o;
    logic          hilo_we_o, div_zero_o, timeout_o;

    int n_checks = 0;
    int n_fail   = 0;
    int stub_lat = 3;
    bit stub_hang = 1'b0;
    bit chk_en = 1'b0;

    div_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .div_req_i(div_req), .signed_i(sgn),
        .reg1_i(reg1), .reg2_i(reg2), .flush_i(flush),
        .div_result_i(div_result), .div_ready_i(div_ready),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .stallreq_o(stallreq_o),
        .hi_o(hi_o), .lo_o(lo_o), .hilo_we_o(hilo_we_o),
        .div_zero_o(div_zero_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Truncating division; remainder carries the dividend's sign; divide by zero gives 0.
    function automatic logic [2*DW-1:0] ref_div(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                 input logic s);
        longint sa, sb, q, r;
        if (b == '0) return '0;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        q = sa / sb;
        r = sa % sb;
        return {r[DW-1:0], q[DW-1:0]};
    endfunction

    // Stub divider: ready after stub_lat cycles of start, held until start drops or annul.
    int d_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d_cnt <= 0;
            div_ready <= 1'b0;
            div_result <= '0;
        end else if (div_annul_o || !div_start_o) begin
            d_cnt <= 0;
            div_ready <= 1'b0;
        end else if (!div_ready && !stub_hang) begin
            if (d_cnt + 1 >= stub_lat) begin
                div_ready <= 1'b1;
                div_result <= ref_div(div_op1_o, div_op2_o, div_signed_o);
            end
            d_cnt <= d_cnt + 1;
        end
    end

    // Behavioural model of the controller.
    int            m_phase = M_IDLE;
    int            m_busy = 0;
    int            m_txn = 0;
    logic          m_start = 0, m_annul = 0, m_sgn = 0, m_we = 0, m_zero = 0, m_to = 0;
    logic [DW-1:0] m_op1 = '0, m_op2 = '0, m_hi = '0, m_lo = '0;
    logic [2*DW-1:0] m_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = M_IDLE; m_busy = 0;
            m_start = 0; m_annul = 0; m_sgn = 0; m_we = 0; m_zero = 0; m_to = 0;
            m_op1 = '0; m_op2 = '0; m_hi = '0; m_lo = '0;
        end else begin
            m_we = 0; m_annul = 0; m_to = 0;
            case (m_phase)
                M_IDLE: if (div_req && !flush) begin
                    m_op1 = reg1; m_op2 = reg2; m_sgn = sgn;
                    m_zero = (reg2 == 0);
                    m_start = 1; m_busy = 0; m_phase = M_BUSY;
                end
                M_BUSY: begin
                    m_busy++;
                    if (flush || (m_busy == TO && !div_ready)) begin
                        m_to = !flush;
                        m_start = 0; m_annul = 1; m_phase = M_DRAIN;
                        $display("txn %0d: abort op1=%h op2=%h timeout=%0d", m_txn, m_op1, m_op2, m_to);
                        m_txn++;
                    end else if (div_ready) begin
                        m_res = ref_div(m_op1, m_op2, m_sgn);
                        m_hi = m_res[2*DW-1:DW];
                        m_lo = m_res[DW-1:0];
                        m_we = 1; m_start = 0; m_phase = M_DONE;
                        $display("txn %0d: op1=%h op2=%h signed=%0d -> hi=%h lo=%h",
                                 m_txn, m_op1, m_op2, m_sgn, m_hi, m_lo);
                        m_txn++;
                    end
                end
                M_DONE: m_phase = M_DRAIN;
                default: if (!div_ready) m_phase = M_IDLE;
            endcase
        end
    end

    logic start_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            check("start", div_start_o, m_start);
            check("annul", div_annul_o, m_annul);
            check("signed", div_signed_o, m_sgn);
            check("op1", div_op1_o, m_op1);
            check("op2", div_op2_o, m_op2);
            check("stall", stallreq_o,
                  (div_req && !flush && (m_phase == M_IDLE || m_phase == M_DRAIN)) || m_phase == M_BUSY);
            check("hi", hi_o, m_hi);
            check("lo", lo_o, m_lo);
            check("hilo_we", hilo_we_o, m_we);
            check("div_zero", div_zero_o, m_zero);
            check("timeout", timeout_o, m_to);
            if (div_start_o && !start_prev) check("start_rise_ready_low", div_ready, 1'b0);
        end
        start_prev = div_start_o;
    end

    task automatic run_div(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                           input bit keep);
        bit seen;
        seen = 0;
        div_req = 1; reg1 = a; reg2 = b; sgn = s;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (hilo_we_o) seen = 1;
        end
        check("hilo_we_seen", seen, 1'b1);
        if (!keep) div_req = 0;
    endtask

    initial begin
        int waited;
        bit seen;
        repeat (3) @(negedge clk);
        check("rst_stall", stallreq_o, 1'b0);
        check("rst_start", div_start_o, 1'b0);
        check("rst_hi", hi_o, 24'h0);
        check("rst_lo", lo_o, 24'h0);
        check("rst_zero", div_zero_o, 1'b0);
        rst = 0;
        chk_en = 1;

        run_div(24'd100, 24'd7, 1'b0, 1'b0);
        check("u100_7_lo", lo_o, 24'd14);
        check("u100_7_hi", hi_o, 24'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("u100_7_single_we", hilo_we_o, 1'b0);
        end

        run_div(24'hFFFFF9, 24'h000002, 1'b1, 1'b0);
        check("s_m7_2_lo", lo_o, 24'hFFFFFD);
        check("s_m7_2_hi", hi_o, 24'hFFFFFF);

        run_div(24'd5, 24'd0, 1'b0, 1'b0);
        check("dz_hi", hi_o, 24'h0);
        check("dz_lo", lo_o, 24'h0);
        check("dz_flag", div_zero_o, 1'b1);

        run_div(24'd20, 24'd3, 1'b0, 1'b1);
        check("b2b1_lo", lo_o, 24'd6);
        check("b2b1_hi", hi_o, 24'd2);
        check("dz_cleared", div_zero_o, 1'b0);
        run_div(24'd9, 24'd4, 1'b0, 1'b0);
        check("b2b2_lo", lo_o, 24'd2);
        check("b2b2_hi", hi_o, 24'd1);

        // Flush five cycles into a long divide.
        stub_lat = 12;
        div_req = 1; reg1 = 24'd50; reg2 = 24'd5; sgn = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (div_start_o) seen = 1;
        end
        check("flush_started", seen, 1'b1);
        repeat (5) @(negedge clk);
        flush = 1; div_req = 0;
        @(negedge clk);
        check("flush_annul", div_annul_o, 1'b1);
        flush = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("flush_no_we", hilo_we_o, 1'b0);
        end
        check("flush_hi_kept", hi_o, 24'd1);
        check("flush_lo_kept", lo_o, 24'd2);

        // Divider that never answers.
        stub_hang = 1;
        div_req = 1; reg1 = 24'd7; reg2 = 24'd1;
        waited = 0;
        for (int i = 1; i <= TO + 10 && waited == 0; i++) begin
            @(negedge clk);
            if (i == 1) div_req = 0;
            if (timeout_o) waited = i;
        end
        check("timeout_cycles", waited, TO + 1);
        stub_hang = 0;
        stub_lat = 2;
        repeat (3) @(negedge clk);
        run_div(24'd81, 24'd9, 1'b0, 1'b0);
        check("after_to_lo", lo_o, 24'd9);
        check("after_to_hi", hi_o, 24'd0);

        // Asynchronous reset in the middle of a divide.
        stub_lat = 10;
        div_req = 1; reg1 = 24'd30; reg2 = 24'd4;
        repeat (3) @(negedge clk);
        div_req = 0;
        #2 rst = 1;
        #1;
        check("arst_start", div_start_o, 1'b0);
        check("arst_stall", stallreq_o, 1'b0);
        check("arst_lo", lo_o, 24'h0);
        check("arst_op1", div_op1_o, 24'h0);
        @(negedge clk);
        rst = 0;

        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (!(div_req && stallreq_o)) begin
                div_req = ($urandom_range(0, 2) != 0);
                reg1 = DW'($urandom);
                case ($urandom_range(0, 3))
                    0: reg2 = '0;
                    1: reg2 = DW'($urandom_range(1, 15));
                    2: reg2 = ~DW'($urandom_range(0, 7));
                    default: reg2 = DW'($urandom);
                endcase
                sgn = 1'($urandom_range(0, 1));
            end
            flush = ($urandom_range(0, 24) == 0);
            if (!div_start_o) stub_lat = $urandom_range(1, 8);
        end
        div_req = 0; flush = 0;
        repeat (20) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
